// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_arbiter
// Description : Synchronises raw buttons, latches release edges as pending
//               requests and serialises them round-robin onto a valid/ready
//               event stream, with a per-button post-accept lockout window.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_arbiter #(
    parameter int N_BTN   = 4,
    parameter int IDX_W   = 2,
    parameter int LOCKOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk_d,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] bt,
    input  logic             ev_ready,
    input  logic             clr_ovf,
    output logic             ev_valid,
    output logic [IDX_W-1:0] ev_idx,
    output logic [N_BTN-1:0] ev_onehot,
    output logic [N_BTN-1:0] pending,
    output logic             overflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last_grant;
    logic [N_BTN-1:0] r_onehot;
    logic             r_overflow;

    logic             w_accept;
    logic [N_BTN-1:0] w_pending;
    logic [N_BTN-1:0] w_ovf_set;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand_idx;
    int               w_cand;

    assign w_accept = r_valid & ev_ready;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [2:0]       r_sync;
            logic [CNT_W-1:0] r_lock;
            logic             r_pend;
            logic             w_rel;
            logic             w_acc_sel;
            logic             w_locked;

            assign w_rel         = r_sync[2] & ~r_sync[1];
            assign w_acc_sel     = w_accept && (r_idx == IDX_W'(gi));
            assign w_locked      = (r_lock != '0);
            assign w_ovf_set[gi] = !w_acc_sel && w_rel && !w_locked && r_pend;
            assign w_pending[gi] = r_pend;

            always_ff @(posedge clk_d) begin
                if (!rst_n) begin
                    r_sync <= '0;
                    r_lock <= '0;
                    r_pend <= 1'b0;
                end else begin
                    r_sync <= {r_sync[1:0], bt[gi]};
                    if (w_acc_sel)
                        r_lock <= CNT_W'(LOCKOUT);
                    else if (w_locked)
                        r_lock <= r_lock - CNT_W'(1);
                    // A release coinciding with its own accept is swallowed.
                    if (w_acc_sel)
                        r_pend <= 1'b0;
                    else if (w_rel && !w_locked)
                        r_pend <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_d) begin
        if (!rst_n)
            r_overflow <= 1'b0;
        else if (|w_ovf_set)
            r_overflow <= 1'b1;
        else if (clr_ovf)
            r_overflow <= 1'b0;
    end

    assign w_start = (r_last_grant == IDX_W'(N_BTN - 1)) ? '0 : r_last_grant + IDX_W'(1);

    // Scan from the farthest candidate back to w_start so the nearest pending wins.
    always_comb begin
        w_pick     = w_start;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            w_cand = int'(w_start) + k;
            if (w_cand >= N_BTN)
                w_cand = w_cand - N_BTN;
            w_cand_idx = w_cand[IDX_W-1:0];
            if (w_pending[w_cand_idx])
                w_pick = w_cand_idx;
        end
    end

    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_idx        <= '0;
            r_onehot     <= '0;
            r_last_grant <= IDX_W'(N_BTN - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_idx    <= w_pick;
                        r_valid  <= 1'b1;
                        r_onehot <= N_BTN'(1) << w_pick;
                        r_state  <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_accept) begin
                        r_last_grant <= r_idx;
                        r_valid      <= 1'b0;
                        r_onehot     <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ev_valid  = r_valid;
    assign ev_idx    = r_idx;
    assign ev_onehot = r_onehot;
    assign pending   = w_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
